// File: rtl/tracker_pkg.sv
// Shared encodings for the sun tracker command stage and its servo driver interface.
package tracker_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MOVE_POS = 3'd1,
        S_MOVE_NEG = 3'd2,
        S_SETTLE   = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b10;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tracker_cmp.sv
// Signed sensor difference and the deadband / hysteresis threshold compares.
module tracker_cmp #(
    parameter int ADC_W    = 12,
    parameter int DEADBAND = 64,
    parameter int HYST     = 16
) (
    input  logic [ADC_W-1:0] ldr_a,
    input  logic [ADC_W-1:0] ldr_b,
    output logic             gt_start,
    output logic             lt_start,
    output logic             in_hyst_pos,
    output logic             in_hyst_neg
);

    localparam logic signed [ADC_W:0] DB = (ADC_W+1)'(DEADBAND);
    localparam logic signed [ADC_W:0] HY = (ADC_W+1)'(HYST);

    logic signed [ADC_W:0] diff;

    // One extra bit holds the full unsigned range of A-B without saturation.
    assign diff        = $signed({1'b0, ldr_a}) - $signed({1'b0, ldr_b});
    assign gt_start    = diff > DB;
    assign lt_start    = diff < -DB;
    assign in_hyst_pos = diff <= HY;
    assign in_hyst_neg = diff >= -HY;

endmodule

// File: rtl/sun_tracker_fsm.sv
// Light-balance tracker: turns a sensor pair into one-hot servo move enables
// with deadband, hysteresis, settle time, end-stop blocking and move timeout.
module sun_tracker_fsm
    import tracker_pkg::*;
#(
    parameter int ADC_W         = 12,
    parameter int DEADBAND      = 64,
    parameter int HYST          = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int MOVE_TIMEOUT  = 1000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SAMPLE_VALID,
    input  logic [ADC_W-1:0] LDR_A,
    input  logic [ADC_W-1:0] LDR_B,
    input  logic             LIMIT_POS,
    input  logic             LIMIT_NEG,
    input  logic             CLR_FAULT,
    output logic             BTN_0,
    output logic             BTN_1,
    output logic             FAULT,
    output logic             BUSY
);

    localparam int CNT_MAX = max2(MOVE_TIMEOUT, SETTLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MOVE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic gt_start, lt_start, in_hyst_pos, in_hyst_neg;

    tracker_cmp #(
        .ADC_W   (ADC_W),
        .DEADBAND(DEADBAND),
        .HYST    (HYST)
    ) u_cmp (
        .ldr_a      (LDR_A),
        .ldr_b      (LDR_B),
        .gt_start   (gt_start),
        .lt_start   (lt_start),
        .in_hyst_pos(in_hyst_pos),
        .in_hyst_neg(in_hyst_neg)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dir_q, dir_d;
    logic             fault_q, fault_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (SAMPLE_VALID) begin
                    if (gt_start && !LIMIT_POS)      state_d = S_MOVE_POS;
                    else if (lt_start && !LIMIT_NEG) state_d = S_MOVE_NEG;
                end
            end
            // Timeout outranks the limit switch, which outranks the sample.
            S_MOVE_POS: begin
                if (cnt_q == TO_LAST) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end else if (LIMIT_POS || (SAMPLE_VALID && in_hyst_pos)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_MOVE_NEG: begin
                if (cnt_q == TO_LAST) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end else if (LIMIT_NEG || (SAMPLE_VALID && in_hyst_neg)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == ST_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_FAULT: begin
                cnt_d = '0;
                if (CLR_FAULT) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs decode the next state so they register alongside it.
        dir_d   = (state_d == S_MOVE_POS) ? DIR_POS :
                  (state_d == S_MOVE_NEG) ? DIR_NEG : DIR_STOP;
        fault_d = (state_d == S_FAULT);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_STOP;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            fault_q <= fault_d;
            busy_q  <= busy_d;
        end
    end

    assign BTN_0 = dir_q[0];
    assign BTN_1 = dir_q[1];
    assign FAULT = fault_q;
    assign BUSY  = busy_q;

endmodule
